seq_mult8_ctrl: RTL and testbench

Sequential shift-and-add controller for 8×8 unsigned multiplication. It sits directly upstream of the team's 8-bit ripple-carry adder: every cycle it drives the adder's operand and carry-in inputs and consumes the adder's sum and carry-out. It produces a 16-bit product after a fixed 8-iteration sequence. A start/busy/done handshake connects it to the issuing logic.

---
 rtl/mult_pkg.sv | 12 +
 rtl/seq_mult8_ctrl.sv | 88 ++++++++
 tb/tb_seq_mult8_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and widths for the sequential 8x8 shift-and-add multiplier.
package mult_pkg;
   localparam int MULT_W = 8;
   localparam int PROD_W = 16;
   localparam int CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;
endpackage

// File: rtl/seq_mult8_ctrl.sv
// Shift-and-add controller for 8x8 unsigned multiply; drives an external
// ripple adder each cycle and shifts its 9-bit result into {acc, mq}.
module seq_mult8_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   output logic               add_cin,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic               add_cout
);

   mult_state_t        state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mq_q, mq_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mq_q    <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               acc_d   = '0;
               mq_d    = mplier;
               mcand_d = mcand;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // carry-out becomes the new MSB so no bit of the partial sum is lost
            acc_d = {add_cout, add_sum[WIDTH-1:1]};
            mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d = DONE;
               prod_d  = {add_cout, add_sum, mq_q[WIDTH-1:1]};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign product = prod_q;
   assign add_a   = acc_q;
   assign add_b   = mq_q[0] ? mcand_q : '0;
   assign add_cin = 1'b0;

endmodule

// File: tb/tb_seq_mult8_ctrl.sv
// Directed bench for seq_mult8_ctrl with a behavioural adder; a monitor
// pops expected products from a queue on every done pulse.
module tb_seq_mult8_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  mcand, mplier;
   logic        busy, done;
   logic [15:0] product;
   logic [7:0]  add_a, add_b, add_sum;
   logic        add_cin, add_cout;

   int tests = 0;
   int fails = 0;
   logic [15:0] exp_q[$];

   seq_mult8_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
      .busy(busy), .done(done), .product(product),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   // external ripple adder stand-in
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
         if (done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else chk("product", {16'h0, product}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   // one operation; optionally pulse start with junk operands in RUN cycle glitch_at
   task automatic mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                      input int glitch_at, output int busy_cnt, output int edges,
                      output logic bnz, output logic pchg);
      logic [15:0] p0;
      busy_cnt = 0; edges = -1; bnz = 1'b0; pchg = 1'b0;
      @(negedge clk);
      mcand = a; mplier = b; start = 1'b1;
      p0 = product;
      exp_q.push_back(exp);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin edges = i + 1; break; end
         if (busy) begin
            busy_cnt++;
            if (add_b != 8'h00) bnz = 1'b1;
            if (product != p0) pchg = 1'b1;
         end
         mcand = 8'h55; mplier = 8'h66;
         start = (busy_cnt == glitch_at);
         @(negedge clk);
      end
      start = 1'b0;
      if (edges < 0) chk("done_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int bc, ed, gap, d1, d2;
      logic bnz, pchg, pchg2;
      rst = 1'b1; start = 1'b0; mcand = 8'h00; mplier = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_product", {16'd0, product}, 32'h0);
      chk("rst_add_a", {24'd0, add_a}, 32'h0);
      chk("rst_add_b", {24'd0, add_b}, 32'h0);
      chk("rst_add_cin", {31'd0, add_cin}, 32'h0);
      rst = 1'b0;

      mul(8'h0F, 8'h0F, 16'h00E1, -1, bc, ed, bnz, pchg);
      chk("0f_busy_cycles", bc, 32'd8);
      chk("0f_done_edge", ed, 32'd9);
      chk("0f_prod_stable", {31'd0, pchg}, 32'd0);
      @(negedge clk);
      chk("0f_done_drop", {31'd0, done}, 32'd0);
      chk("0f_prod_hold", {16'd0, product}, 32'h00E1);

      mul(8'hFF, 8'hFF, 16'hFE01, -1, bc, ed, bnz, pchg);
      chk("ff_busy_cycles", bc, 32'd8);

      mul(8'h00, 8'hA5, 16'h0000, -1, bc, ed, bnz, pchg);
      mul(8'hA5, 8'h00, 16'h0000, -1, bc, ed, bnz, pchg);
      chk("zero_mplier_add_b", {31'd0, bnz}, 32'd0);

      mul(8'h12, 8'h34, 16'h03A8, 3, bc, ed, bnz, pchg);
      chk("glitch_busy_cycles", bc, 32'd8);
      repeat (12) @(negedge clk);
      chk("glitch_idle", {30'd0, busy, done}, 32'd0);

      // reset abort in RUN cycle 5
      @(negedge clk);
      mcand = 8'hFF; mplier = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_product", {16'd0, product}, 32'h0);
      repeat (12) @(negedge clk);
      chk("abort_no_restart", {30'd0, busy, done}, 32'd0);
      mul(8'h03, 8'h07, 16'h0015, -1, bc, ed, bnz, pchg);

      // back-to-back with start held through DONE
      @(negedge clk);
      mcand = 8'h10; mplier = 8'h10; start = 1'b1;
      exp_q.push_back(16'h0100);
      exp_q.push_back(16'h0100);
      d1 = -1; d2 = -1; pchg2 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done && d1 < 0) begin
            d1 = i;
            mcand = 8'h02; mplier = 8'h80;
         end else if (done && d2 < 0) begin
            d2 = i;
         end else if (d1 >= 0) begin
            start = 1'b0;
            if (busy && product != 16'h0100) pchg2 = 1'b1;
         end
         if (d2 >= 0) break;
      end
      start = 1'b0;
      gap = d2 - d1;
      chk("b2b_first_done", d1, 32'd8);
      chk("b2b_gap", gap, 32'd9);
      chk("b2b_prod_stable", {31'd0, pchg2}, 32'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end
endmodule
